relobi_r_other_err_tracker: RTL

Error-tracking stage directly downstream of the reliable-OBI R-channel "other fields" ECC decoder.
- Consumes the decoder's 2-bit relerr flags and decoded rid on every accepted R beat.
- Keeps saturating correctable and uncorrectable error counters.
- Captures the first faulty beat's rid and error type.
- Raises a sticky interrupt for software or a safety manager until it is explicitly cleared.

---
 rtl/relobi_r_other_err_tracker.sv | 130 +++++++++++++
 1 files changed

// File: rtl/relobi_r_other_err_tracker.sv
// Error tracker behind the reliable-OBI R-channel "other fields" ECC decoder: saturating
// counters, first-error capture and sticky irq. Define RELOBI_ERR_THRESH_EN for a correctable-error threshold irq.
package obi_pkg;
  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};
endpackage

module relobi_r_other_err_tracker #(
  parameter obi_pkg::obi_cfg_t Cfg           = obi_pkg::ObiDefaultConfig,
  parameter int unsigned       CntWidth      = 16,
  parameter int unsigned       ThreshDefault = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rvalid_i,
  input  logic                   rready_i,
  input  logic [Cfg.IdWidth-1:0] rid_i,
  input  logic [1:0]             relerr_i,
  input  logic                   clear_i,
`ifdef RELOBI_ERR_THRESH_EN
  input  logic [CntWidth-1:0]    thresh_i,
  input  logic                   thresh_we_i,
`endif
  output logic [CntWidth-1:0]    corr_cnt_o,
  output logic [CntWidth-1:0]    uncorr_cnt_o,
  output logic                   first_err_valid_o,
  output logic [Cfg.IdWidth-1:0] first_err_rid_o,
  output logic                   first_err_fatal_o,
  output logic                   irq_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOGGED = 2'd1;
  localparam logic [1:0] FATAL  = 2'd2;

  localparam logic [CntWidth-1:0] CntMax = '1;

  logic [1:0]             state_q, state_d;
  logic [CntWidth-1:0]    corr_q, corr_d;
  logic [CntWidth-1:0]    uncorr_q, uncorr_d;
  logic [Cfg.IdWidth-1:0] rid_q, rid_d;
  logic                   fatal_q, fatal_d;
  logic                   irq_q, irq_d;
  logic                   hs, is_uncorr, is_corr;

  assign hs        = rvalid_i && rready_i;
  assign is_uncorr = hs && relerr_i[1];
  assign is_corr   = hs && (relerr_i == 2'b01);

  // Clear is applied first so a beat in the same cycle lands in the fresh state.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    corr_d   = corr_q;
    uncorr_d = uncorr_q;
    rid_d    = rid_q;
    fatal_d  = fatal_q;

    if (clear_i) begin
      state_d  = IDLE;
      corr_d   = '0;
      uncorr_d = '0;
      rid_d    = '0;
      fatal_d  = 1'b0;
    end

    if (is_uncorr) begin
      if (uncorr_d != CntMax) uncorr_d = uncorr_d + CntWidth'(1);
      if (state_d == IDLE) begin
        rid_d   = rid_i;
        fatal_d = 1'b1;
      end
      state_d = FATAL;
    end else if (is_corr) begin
      if (corr_d != CntMax) corr_d = corr_d + CntWidth'(1);
      if (state_d == IDLE) begin
        state_d = LOGGED;
        rid_d   = rid_i;
        fatal_d = 1'b0;
      end
    end
  end

`ifdef RELOBI_ERR_THRESH_EN
  logic [CntWidth-1:0] thresh_q, thresh_d;

  // The threshold is configuration, so clear_i leaves it alone.
  assign thresh_d = thresh_we_i ? thresh_i : thresh_q;
  assign irq_d    = (state_d == FATAL) || ((thresh_d != '0) && (corr_d >= thresh_d));

  always_ff @(posedge clk_i) begin
    if (rst_i) thresh_q <= CntWidth'(ThreshDefault);
    else       thresh_q <= thresh_d;
  end
`else
  assign irq_d = (state_d == FATAL);
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      corr_q   <= '0;
      uncorr_q <= '0;
      rid_q    <= '0;
      fatal_q  <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      corr_q   <= corr_d;
      uncorr_q <= uncorr_d;
      rid_q    <= rid_d;
      fatal_q  <= fatal_d;
      irq_q    <= irq_d;
    end
  end

  assign corr_cnt_o        = corr_q;
  assign uncorr_cnt_o      = uncorr_q;
  assign first_err_valid_o = (state_q != IDLE);
  assign first_err_rid_o   = rid_q;
  assign first_err_fatal_o = fatal_q;
  assign irq_o             = irq_q;

endmodule
